// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates entries at dispatch, captures CDB results
// out of order and retires one entry per cycle in program order onto the commit bus.
module reorder_buffer #(
  parameter int WIDTH = 31,
  parameter int ROB   = 2,
  parameter int REG   = 4,
  parameter int INDEX = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dispValid,
  input  logic [3:0]       dispInfo,
  input  logic [REG:0]     dispDest,
  input  logic [INDEX:0]   dispPHTIndex,
  input  logic [WIDTH:0]   dispStatus,
  input  logic [WIDTH:0]   dispPC,
  input  logic             cdbValid,
  input  logic [ROB:0]     cdbROB,
  input  logic [WIDTH:0]   cdbResult,
  input  logic             cdbMispredict,
  input  logic [WIDTH:0]   cdbTarget,
  output logic [ROB:0]     robAllocation,
  output logic             fullRob,
  output logic             validCommit,
  output logic [ROB:0]     commitROB,
  output logic [REG:0]     destCommit,
  output logic [WIDTH:0]   result,
  output logic [3:0]       commitInfo,
  output logic [INDEX:0]   commitPHTIndex,
  output logic [WIDTH:0]   statusSnap,
  output logic [1:0]       controlFlow,
  output logic [WIDTH:0]   redirectPC
);
  localparam int DEPTH = 2 ** (ROB + 1);
  localparam logic [ROB+1:0] FULL_CNT = {1'b1, {(ROB + 1){1'b0}}};
  localparam logic [ROB+1:0] CNT_ONE  = {{(ROB + 1){1'b0}}, 1'b1};
  localparam logic [ROB:0]   IDX_ONE  = {{ROB{1'b0}}, 1'b1};

  logic [ROB:0]       head_r;
  logic [ROB:0]       tail_r;
  logic [ROB+1:0]     count_r;
  logic [DEPTH-1:0]   valid_r;
  logic [DEPTH-1:0]   ready_r;
  logic [DEPTH-1:0]   mispredict_r;
  logic [3:0]         info_r   [DEPTH];
  logic [REG:0]       dest_r   [DEPTH];
  logic [INDEX:0]     pht_r    [DEPTH];
  logic [WIDTH:0]     status_r [DEPTH];
  logic [WIDTH:0]     pc_r     [DEPTH];
  logic [WIDTH:0]     result_r [DEPTH];
  logic [WIDTH:0]     target_r [DEPTH];

  logic               do_disp_s;
  logic               do_wb_s;
  logic               do_commit_s;
  logic               flush_s;
  logic [DEPTH-1:0]   valid_nxt_s;
  logic [DEPTH-1:0]   ready_nxt_s;

  assign robAllocation = tail_r;
  assign fullRob       = (count_r == FULL_CNT);

  // Per-cycle handshake decisions and next entry-state vectors.
  always_comb begin
    do_disp_s   = dispValid & ~fullRob;
    do_wb_s     = cdbValid & valid_r[cdbROB];
    do_commit_s = valid_r[head_r] & ready_r[head_r];
    flush_s     = do_commit_s & mispredict_r[head_r];
    valid_nxt_s = valid_r;
    ready_nxt_s = ready_r;
    if (do_wb_s) begin
      ready_nxt_s[cdbROB] = 1'b1;
    end else begin
      ready_nxt_s = ready_nxt_s;
    end
    if (do_commit_s) begin
      valid_nxt_s[head_r] = 1'b0;
      ready_nxt_s[head_r] = 1'b0;
    end else begin
      valid_nxt_s = valid_nxt_s;
    end
    // The tail slot is never the committing head here: that needs count 0 or full.
    if (do_disp_s) begin
      valid_nxt_s[tail_r] = 1'b1;
      ready_nxt_s[tail_r] = 1'b0;
    end else begin
      valid_nxt_s = valid_nxt_s;
    end
  end

  // Pointer, occupancy and entry-state registers; a retired mispredict empties the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      valid_r <= '0;
      ready_r <= '0;
    end else if (flush_s) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      valid_r <= '0;
      ready_r <= '0;
    end else begin
      valid_r <= valid_nxt_s;
      ready_r <= ready_nxt_s;
      if (do_disp_s) begin
        tail_r <= tail_r + IDX_ONE;
      end
      if (do_commit_s) begin
        head_r <= head_r + IDX_ONE;
      end
      case ({do_disp_s, do_commit_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry payload storage; contents are only meaningful while the entry is valid.
  always_ff @(posedge clk) begin
    if (do_disp_s) begin
      info_r[tail_r]   <= dispInfo;
      dest_r[tail_r]   <= dispDest;
      pht_r[tail_r]    <= dispPHTIndex;
      status_r[tail_r] <= dispStatus;
      pc_r[tail_r]     <= dispPC;
    end
    if (do_wb_s) begin
      result_r[cdbROB]     <= cdbResult;
      target_r[cdbROB]     <= cdbTarget;
      mispredict_r[cdbROB] <= cdbMispredict;
    end
  end

  // Registered commit bus, valid for the single cycle after retirement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validCommit    <= 1'b0;
      commitROB      <= '0;
      destCommit     <= '0;
      result         <= '0;
      commitInfo     <= 4'b0000;
      commitPHTIndex <= '0;
      statusSnap     <= '0;
      controlFlow    <= 2'b00;
      redirectPC     <= '0;
    end else if (do_commit_s) begin
      validCommit    <= 1'b1;
      commitROB      <= head_r;
      destCommit     <= dest_r[head_r];
      result         <= result_r[head_r];
      commitInfo     <= info_r[head_r];
      commitPHTIndex <= pht_r[head_r];
      statusSnap     <= status_r[head_r];
      controlFlow    <= {info_r[head_r][1] | info_r[head_r][0], mispredict_r[head_r]};
      redirectPC     <= mispredict_r[head_r] ? target_r[head_r] : '0;
    end else begin
      validCommit    <= 1'b0;
      controlFlow    <= 2'b00;
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Randomized scoreboard bench for reorder_buffer; the reference model keeps the in-flight
// instructions as a program-ordered queue.
module tb_reorder_buffer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dispValid = 1'b0;
  logic [3:0]  dispInfo = 4'd0;
  logic [4:0]  dispDest = 5'd0;
  logic [7:0]  dispPHTIndex = 8'd0;
  logic [31:0] dispStatus = 32'd0;
  logic [31:0] dispPC = 32'd0;
  logic        cdbValid = 1'b0;
  logic [2:0]  cdbROB = 3'd0;
  logic [31:0] cdbResult = 32'd0;
  logic        cdbMispredict = 1'b0;
  logic [31:0] cdbTarget = 32'd0;
  logic [2:0]  robAllocation;
  logic        fullRob;
  logic        validCommit;
  logic [2:0]  commitROB;
  logic [4:0]  destCommit;
  logic [31:0] result;
  logic [3:0]  commitInfo;
  logic [7:0]  commitPHTIndex;
  logic [31:0] statusSnap;
  logic [1:0]  controlFlow;
  logic [31:0] redirectPC;

  reorder_buffer dut (
    .clk(clk), .rst_n(rst_n), .dispValid(dispValid), .dispInfo(dispInfo), .dispDest(dispDest),
    .dispPHTIndex(dispPHTIndex), .dispStatus(dispStatus), .dispPC(dispPC), .cdbValid(cdbValid),
    .cdbROB(cdbROB), .cdbResult(cdbResult), .cdbMispredict(cdbMispredict), .cdbTarget(cdbTarget),
    .robAllocation(robAllocation), .fullRob(fullRob), .validCommit(validCommit),
    .commitROB(commitROB), .destCommit(destCommit), .result(result), .commitInfo(commitInfo),
    .commitPHTIndex(commitPHTIndex), .statusSnap(statusSnap), .controlFlow(controlFlow),
    .redirectPC(redirectPC)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned idx;
    bit [4:0]  dest;
    bit [3:0]  info;
    bit [7:0]  pht;
    bit [31:0] status;
    bit [31:0] pc;
    bit [31:0] res;
    bit [31:0] tgt;
    bit        ready;
    bit        misp;
  } inst_t;

  typedef struct {
    bit [2:0]  idx;
    bit [4:0]  dest;
    bit [31:0] res;
    bit [3:0]  info;
    bit [7:0]  pht;
    bit [31:0] status;
    bit [1:0]  cf;
    bit [31:0] redirect;
  } commit_t;

  inst_t       rob_q[$];
  commit_t     exp_q[$];
  int unsigned next_idx = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input bit ok, input string name, input string detail);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Monitor: compares every presented commit against the oldest expected retirement.
  initial begin
    commit_t e;
    forever begin
      @(negedge clk);
      if (validCommit) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_commit", $sformatf("got entry %0d, expected none", commitROB));
        end else begin
          e = exp_q.pop_front();
          check(commitROB == e.idx && destCommit == e.dest && result == e.res &&
                commitInfo == e.info && commitPHTIndex == e.pht && statusSnap == e.status &&
                controlFlow == e.cf && redirectPC == e.redirect, "commit",
                $sformatf("got rob=%0d dest=%0d res=%h info=%b pht=%h st=%h cf=%b pc=%h, expected rob=%0d dest=%0d res=%h info=%b pht=%h st=%h cf=%b pc=%h",
                          commitROB, destCommit, result, commitInfo, commitPHTIndex, statusSnap, controlFlow, redirectPC,
                          e.idx, e.dest, e.res, e.info, e.pht, e.status, e.cf, e.redirect));
        end
      end else begin
        check(controlFlow == 2'b00, "idle_controlflow", $sformatf("got %b, expected 00", controlFlow));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check(1'b0, "missing_commit", $sformatf("got no commit, expected entry %0d", e.idx));
        end
      end
    end
  end

  // Reference model: one clock edge applied to the program-ordered queue.
  task automatic model_edge(input bit dv, input bit [3:0] di, input bit [4:0] dd, input bit [7:0] dp,
                            input bit [31:0] ds, input bit [31:0] dpc, input bit cv, input bit [2:0] cr,
                            input bit [31:0] res, input bit mp, input bit [31:0] tg);
    bit full, com, fl;
    inst_t n;
    commit_t c;
    full = (rob_q.size() == 8);
    com  = (rob_q.size() > 0) && rob_q[0].ready;
    fl   = com && rob_q[0].misp;
    if (com) begin
      c.idx = rob_q[0].idx[2:0]; c.dest = rob_q[0].dest; c.res = rob_q[0].res;
      c.info = rob_q[0].info; c.pht = rob_q[0].pht; c.status = rob_q[0].status;
      c.cf = {rob_q[0].info[1] | rob_q[0].info[0], rob_q[0].misp};
      c.redirect = rob_q[0].misp ? rob_q[0].tgt : 32'd0;
      exp_q.push_back(c);
    end
    if (cv) begin
      foreach (rob_q[i]) begin
        if (rob_q[i].idx == int'(cr)) begin
          rob_q[i].res = res; rob_q[i].misp = mp; rob_q[i].tgt = tg; rob_q[i].ready = 1'b1;
        end
      end
    end
    if (com) void'(rob_q.pop_front());
    if (fl) begin
      rob_q.delete();
      next_idx = 0;
    end else if (dv && !full) begin
      n.idx = next_idx; n.dest = dd; n.info = di; n.pht = dp; n.status = ds; n.pc = dpc;
      n.res = 32'd0; n.tgt = 32'd0; n.ready = 1'b0; n.misp = 1'b0;
      rob_q.push_back(n);
      next_idx = (next_idx + 1) % 8;
    end
  endtask

  // One cycle: drive inputs, check allocation view, advance DUT and model together.
  task automatic step(input bit dv, input bit [3:0] di, input bit [4:0] dd, input bit cv,
                      input bit [2:0] cr, input bit [31:0] res, input bit mp, input bit [31:0] tg);
    bit [7:0]  dp;
    bit [31:0] ds, dpc;
    dp = 8'($urandom); ds = $urandom; dpc = $urandom;
    dispValid = dv; dispInfo = di; dispDest = dd; dispPHTIndex = dp; dispStatus = ds; dispPC = dpc;
    cdbValid = cv; cdbROB = cr; cdbResult = res; cdbMispredict = mp; cdbTarget = tg;
    #1;
    check(robAllocation == 3'(next_idx), "robAllocation",
          $sformatf("got %0d, expected %0d", robAllocation, next_idx));
    check(fullRob == (rob_q.size() == 8), "fullRob",
          $sformatf("got %0d, expected %0d", fullRob, rob_q.size() == 8));
    @(posedge clk);
    model_edge(dv, di, dd, dp, ds, dpc, cv, cr, res, mp, tg);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 5'd0, 1'b0, 3'd0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic disp(input bit [3:0] di, input bit [4:0] dd);
    step(1'b1, di, dd, 1'b0, 3'd0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic wb(input bit [2:0] cr, input bit [31:0] res, input bit mp, input bit [31:0] tg);
    step(1'b0, 4'd0, 5'd0, 1'b1, cr, res, mp, tg);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    dispValid = 1'b0; cdbValid = 1'b0;
    #1;
    check(robAllocation == 3'd0 && fullRob == 1'b0 && validCommit == 1'b0 && controlFlow == 2'b00,
          "reset_outputs", $sformatf("got alloc=%0d full=%0d vc=%0d cf=%b, expected all 0",
                                     robAllocation, fullRob, validCommit, controlFlow));
    rob_q.delete(); exp_q.delete(); next_idx = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    bit [2:0] pick;
    int unsigned pend[$];
    @(negedge clk); #1;
    do_reset();
    for (int i = 1; i <= 3; i++) disp(4'b1000, 5'(i));
    do_reset();
    for (int i = 1; i <= 9; i++) disp(4'b1000, 5'(i));
    wb(3'd2, 32'h22, 1'b0, 32'd0);
    wb(3'd0, 32'h11, 1'b0, 32'd0);
    wb(3'd1, 32'h33, 1'b0, 32'd0);
    for (int i = 3; i < 8; i++) wb(3'(i), 32'h100 + 32'(i), 1'b0, 32'd0);
    idle(3);
    for (int i = 0; i < 8; i++) disp(4'b1000, 5'(10 + i));
    wb(3'd0, 32'h50, 1'b0, 32'd0);
    disp(4'b1000, 5'd20);
    disp(4'b1000, 5'd21);
    for (int i = 1; i < 8; i++) wb(3'(i), 32'h60 + 32'(i), 1'b0, 32'd0);
    wb(3'd0, 32'h70, 1'b0, 32'd0);
    idle(3);
    do_reset();
    disp(4'b1000, 5'd1);
    disp(4'b1001, 5'd2);
    disp(4'b1000, 5'd3);
    disp(4'b0010, 5'd4);
    wb(3'd3, 32'h3, 1'b0, 32'd0);
    wb(3'd2, 32'h2, 1'b0, 32'd0);
    wb(3'd1, 32'h1004, 1'b1, 32'h400);
    wb(3'd0, 32'h0, 1'b0, 32'd0);
    disp(4'b1000, 5'd9);
    disp(4'b1000, 5'd9);
    idle(2);
    do_reset();
    wb(3'd5, 32'hdead, 1'b0, 32'd0);
    for (int i = 0; i < 6; i++) disp(4'b1000, 5'(i + 1));
    for (int i = 0; i < 5; i++) wb(3'(i), 32'h200 + 32'(i), 1'b0, 32'd0);
    idle(4);
    wb(3'd5, 32'h205, 1'b0, 32'd0);
    idle(2);
    for (int phase = 0; phase < 2; phase++) begin
      for (int c = 0; c < 250; c++) begin
        pend.delete();
        foreach (rob_q[i]) if (!rob_q[i].ready) pend.push_back(rob_q[i].idx);
        if (pend.size() > 0 && $urandom_range(3, 0) != 0)
          pick = 3'(pend[$urandom_range(pend.size() - 1, 0)]);
        else
          pick = 3'($urandom_range(7, 0));
        step($urandom_range(9, 0) < 6, 4'($urandom), 5'($urandom), $urandom_range(9, 0) < (phase == 0 ? 4 : 8),
             pick, $urandom, $urandom_range(11, 0) == 0, $urandom);
      end
    end
    for (int k = 0; k < 3; k++) begin
      pend.delete();
      foreach (rob_q[i]) if (!rob_q[i].ready) pend.push_back(rob_q[i].idx);
      foreach (pend[i]) wb(3'(pend[i]), $urandom, 1'b0, 32'd0);
    end
    idle(10);
    check(rob_q.size() == 0 && exp_q.size() == 0, "drained",
          $sformatf("got %0d in flight / %0d pending commits, expected 0/0", rob_q.size(), exp_q.size()));
    do_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
